nic_fifo: RTL and testbench
===========================

Name: nic_fifo

Overview:
- Parametrised successor to the single-slot `nic`. It sits between the CPU register interface and a router PE port (`pesi`/`pero`/`pedi`, `peso`/`peri`/`pedo`, `polarity_out`).
- Replaces the one-entry input and output buffers with independent FIFOs of configurable depth.
- Reports occupancy in the status words.
- Gates injection on the virtual-channel (VC) bit of the packet against router polarity, so the CPU can queue bursts without polling per packet.

Parameters:
- PACKET_WIDTH, 64, packet and CPU data width; bit 0 is the VC bit (MSB, [0:W-1] indexing).
- OUT_DEPTH, 4, CPU->network FIFO entries; power of 2, range 2..128.
- IN_DEPTH, 4, network->CPU FIFO entries; power of 2, range 2..128.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- addr  in  2  CPU register select: 00 in-data, 01 in-status, 10 out-data, 11 out-status.
- d_in  in  PACKET_WIDTH  CPU write data.
- d_out  out  PACKET_WIDTH  CPU read data, registered.
- nicEn  in  1  CPU access strobe.
- nicEnWR  in  1  1 = write, 0 = read; qualified by nicEn.
- net_si  in  1  router delivers a packet this cycle.
- net_di  in  PACKET_WIDTH  delivered packet.
- net_ri  out  1  NIC can accept a packet.
- net_so  out  1  NIC injects a packet this cycle.
- net_do  out  PACKET_WIDTH  injected packet.
- net_ro  in  1  router can accept an injection.
- net_polarity  in  1  router polarity; toggles each cycle.

Behaviour:
- Reset (reset=0, asynchronous):
  - Both FIFOs are emptied and their pointers and counts cleared.
  - d_out = 0, net_so = 0, net_do = 0.
  - net_ri = 1 once reset is released. net_ri is combinational from the input-FIFO full flag.
  - A reset mid-burst discards all queued packets. No partial state survives.
- net_ri:
  - net_ri = !in_full, combinational from registered state.
- Network receive:
  - On an edge with net_si=1 and net_ri=1, net_di is pushed into the input FIFO.
  - net_si while full is dropped. If NIC_ERR_EN is compiled in, it sets in_ovf.
- Network inject (all outputs registered):
  - Condition at the edge: out FIFO not empty, net_ro=1, and head[0] == net_polarity.
  - If the condition holds: net_so<=1, net_do<=head, head is popped.
  - Otherwise: net_so<=0, net_do holds its value.
  - Because polarity toggles every cycle, same-VC packets leave at best every other cycle.
  - Alternating-VC packets can leave on consecutive cycles.
- CPU write:
  - nicEn=1, nicEnWR=1, addr=10: d_in is pushed to the out FIFO.
  - A push is dropped when out_full at the edge. This holds even if an inject pop happens on the same edge. If NIC_ERR_EN is compiled in, it sets out_ovf.
  - Writes to 00, 01 and 11 are ignored.
- CPU read (nicEn=1, nicEnWR=0): d_out is updated at the edge and is valid the following cycle.
  - addr 00: d_out<=in head and the head is popped. If empty, d_out<=0, no pop; with NIC_ERR_EN, sets in_udf.
  - addr 01: d_out<=(in_count<<1) | (in_count!=0).
  - addr 11: d_out<=(out_count<<1) | out_full.
  - addr 10: d_out<=0.
  - When nicEn=0, d_out holds its value.
- Simultaneous push and pop on the same FIFO in the same cycle:
  - Both take effect and the count is unchanged.
  - When the FIFO is empty, a same-cycle pop sees the pre-push state, so no pop occurs.
- Counts:
  - Counts are 8 bits and range 0..DEPTH.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Latency: a CPU write on edge N becomes eligible to inject on edge N+1.

Optional Feature:
- Macro NIC_ERR_EN.
- When defined:
  - Sticky flags in_ovf and in_udf appear in the in-status word at bit weights 2^9 and 2^10.
  - Sticky flag out_ovf appears in the out-status word at bit weight 2^9.
  - Reading a status word clears the flags it reports, on that same edge. A new error event on that same edge wins, so the flag stays set.
- When undefined:
  - Overflow and underflow are silently discarded.
  - Status bits 9 and 10 read 0.

Test Plan:
- Reset, then read addr 01 and addr 11 -> d_out=0 for both; net_ri=1, net_so=0.
- Write 0x0000_0000_0000_0001 (VC 0) to addr 10 with net_ro=1 -> net_so=1 for one cycle with net_do=0x...0001 on the first edge where net_polarity=0. Out-status then reads 0.
- Write 4 packets, VC bits 0,1,0,1, with net_ro=0, then read addr 11 -> 0x9 (count 4, full). Raise net_ro -> four consecutive net_so cycles in write order.
- Write 4 packets to a full OUT_DEPTH=4 FIFO plus a fifth 0xDEADBEEFDEADBEEF -> the fifth never appears on net_do. With NIC_ERR_EN, out-status reads 0x209, then 0x9 on the next read.
- Drive net_si with 5 packets -> net_ri falls after the 4th and the 5th is dropped. Reads of addr 00 return packets 1..4 in order; in-status then reads 0.
- Assert reset low while out count=3 and in count=2 -> net_so=0 and d_out=0 immediately (asynchronous); both status reads return 0 after release.

Source files
------------

// File: rtl/nic_fifo.sv
// NIC between the CPU register port and a router PE port, with separate inject and receive FIFOs.
// Define NIC_ERR_EN to add the sticky overflow/underflow flags to the status words.
module nic_fifo #(
    parameter int PACKET_WIDTH = 64,
    parameter int OUT_DEPTH    = 4,
    parameter int IN_DEPTH     = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              addr,
    input  logic [0:PACKET_WIDTH-1] d_in,
    output logic [0:PACKET_WIDTH-1] d_out,
    input  logic                    nicEn,
    input  logic                    nicEnWR,
    input  logic                    net_si,
    input  logic [0:PACKET_WIDTH-1] net_di,
    output logic                    net_ri,
    output logic                    net_so,
    output logic [0:PACKET_WIDTH-1] net_do,
    input  logic                    net_ro,
    input  logic                    net_polarity
);

    localparam int OAW = $clog2(OUT_DEPTH);
    localparam int IAW = $clog2(IN_DEPTH);
    localparam logic [7:0] OUT_FULL_CNT = 8'(OUT_DEPTH);
    localparam logic [7:0] IN_FULL_CNT  = 8'(IN_DEPTH);

    logic [0:PACKET_WIDTH-1] out_mem [OUT_DEPTH];
    logic [0:PACKET_WIDTH-1] in_mem  [IN_DEPTH];

    logic [OAW-1:0] out_wr_ptr_q, out_wr_ptr_d, out_rd_ptr_q, out_rd_ptr_d;
    logic [IAW-1:0] in_wr_ptr_q, in_wr_ptr_d, in_rd_ptr_q, in_rd_ptr_d;
    logic [7:0]     out_cnt_q, out_cnt_d, in_cnt_q, in_cnt_d;
    logic [0:PACKET_WIDTH-1] d_out_q, d_out_d, net_do_q, net_do_d;
    logic                    net_so_q, net_so_d;

    logic out_full, out_empty, in_full, in_empty;
    logic cpu_rd, cpu_wr;
    logic out_push_req, out_push, out_pop;
    logic in_push, in_pop_req, in_pop;
    logic in_ovf, in_udf, out_ovf;
    logic [0:PACKET_WIDTH-1] out_head, in_head, in_status, out_status;

    always_comb begin
        out_full     = (out_cnt_q == OUT_FULL_CNT);
        out_empty    = (out_cnt_q == 8'd0);
        in_full      = (in_cnt_q == IN_FULL_CNT);
        in_empty     = (in_cnt_q == 8'd0);
        out_head     = out_mem[out_rd_ptr_q];
        in_head      = in_mem[in_rd_ptr_q];
        cpu_rd       = nicEn & ~nicEnWR;
        cpu_wr       = nicEn & nicEnWR;
        out_push_req = cpu_wr && (addr == 2'b10);
        out_push     = out_push_req & ~out_full;
        // Only the VC that matches the router's current polarity may leave.
        out_pop      = ~out_empty & net_ro & (out_head[0] == net_polarity);
        in_push      = net_si & ~in_full;
        in_pop_req   = cpu_rd && (addr == 2'b00);
        in_pop       = in_pop_req & ~in_empty;
        in_status    = PACKET_WIDTH'({in_udf, in_ovf, in_cnt_q, ~in_empty});
        out_status   = PACKET_WIDTH'({out_ovf, out_cnt_q, out_full});
    end

    always_comb begin
        out_wr_ptr_d = out_push ? out_wr_ptr_q + 1'b1 : out_wr_ptr_q;
        out_rd_ptr_d = out_pop  ? out_rd_ptr_q + 1'b1 : out_rd_ptr_q;
        in_wr_ptr_d  = in_push  ? in_wr_ptr_q + 1'b1 : in_wr_ptr_q;
        in_rd_ptr_d  = in_pop   ? in_rd_ptr_q + 1'b1 : in_rd_ptr_q;
        out_cnt_d    = out_cnt_q + {7'd0, out_push} - {7'd0, out_pop};
        in_cnt_d     = in_cnt_q + {7'd0, in_push} - {7'd0, in_pop};
        net_so_d     = out_pop;
        net_do_d     = out_pop ? out_head : net_do_q;
        d_out_d      = d_out_q;
        if (cpu_rd) begin
            case (addr)
                2'b00:   d_out_d = in_empty ? '0 : in_head;
                2'b01:   d_out_d = in_status;
                2'b10:   d_out_d = '0;
                default: d_out_d = out_status;
            endcase
        end
    end

    // Storage is not reset; pointers and counts define what is valid.
    always_ff @(posedge clk) begin
        if (out_push) out_mem[out_wr_ptr_q] <= d_in;
        if (in_push)  in_mem[in_wr_ptr_q]   <= net_di;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_wr_ptr_q <= '0;
            out_rd_ptr_q <= '0;
            in_wr_ptr_q  <= '0;
            in_rd_ptr_q  <= '0;
            out_cnt_q    <= '0;
            in_cnt_q     <= '0;
            d_out_q      <= '0;
            net_so_q     <= 1'b0;
            net_do_q     <= '0;
        end else begin
            out_wr_ptr_q <= out_wr_ptr_d;
            out_rd_ptr_q <= out_rd_ptr_d;
            in_wr_ptr_q  <= in_wr_ptr_d;
            in_rd_ptr_q  <= in_rd_ptr_d;
            out_cnt_q    <= out_cnt_d;
            in_cnt_q     <= in_cnt_d;
            d_out_q      <= d_out_d;
            net_so_q     <= net_so_d;
            net_do_q     <= net_do_d;
        end
    end

`ifdef NIC_ERR_EN
    logic in_ovf_q, in_ovf_d, in_udf_q, in_udf_d, out_ovf_q, out_ovf_d;
    logic in_stat_rd, out_stat_rd;

    // Reading a status word clears its flags, but an error on the same edge re-sets them.
    always_comb begin
        in_stat_rd  = cpu_rd && (addr == 2'b01);
        out_stat_rd = cpu_rd && (addr == 2'b11);
        in_ovf_d    = (in_ovf_q & ~in_stat_rd) | (net_si & in_full);
        in_udf_d    = (in_udf_q & ~in_stat_rd) | (in_pop_req & in_empty);
        out_ovf_d   = (out_ovf_q & ~out_stat_rd) | (out_push_req & out_full);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_ovf_q  <= 1'b0;
            in_udf_q  <= 1'b0;
            out_ovf_q <= 1'b0;
        end else begin
            in_ovf_q  <= in_ovf_d;
            in_udf_q  <= in_udf_d;
            out_ovf_q <= out_ovf_d;
        end
    end

    assign in_ovf  = in_ovf_q;
    assign in_udf  = in_udf_q;
    assign out_ovf = out_ovf_q;
`else
    assign in_ovf  = 1'b0;
    assign in_udf  = 1'b0;
    assign out_ovf = 1'b0;
`endif

    assign d_out  = d_out_q;
    assign net_so = net_so_q;
    assign net_do = net_do_q;
    assign net_ri = ~in_full;

endmodule

// File: tb/tb_nic_fifo.sv
// Scoreboard bench for nic_fifo: injected and CPU-read packets are checked against queues of expected packets.
module tb_nic_fifo;

    localparam logic [1:0] A_IN_DATA  = 2'b00;
    localparam logic [1:0] A_IN_STAT  = 2'b01;
    localparam logic [1:0] A_OUT_DATA = 2'b10;
    localparam logic [1:0] A_OUT_STAT = 2'b11;
`ifdef NIC_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic        clk, reset, nicEn, nicEnWR, net_si, net_ri, net_so, net_ro, net_polarity;
    logic [1:0]  addr;
    logic [0:63] d_in, d_out, net_di, net_do;

    logic [63:0] out_exp[$];
    logic [63:0] in_exp[$];
    int n_chk  = 0;
    int n_pass = 0;

    nic_fifo #(.PACKET_WIDTH(64), .OUT_DEPTH(4), .IN_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
        .nicEn(nicEn), .nicEnWR(nicEnWR), .net_si(net_si), .net_di(net_di),
        .net_ri(net_ri), .net_so(net_so), .net_do(net_do), .net_ro(net_ro),
        .net_polarity(net_polarity)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        net_polarity = 1'b0;
        forever begin
            @(posedge clk);
            #1 net_polarity = ~net_polarity;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Every injection must be the next expected packet, on a VC matching the polarity at that edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (reset && net_so) begin
                if (out_exp.size() == 0) begin
                    check("unexp_so", {63'd0, net_so}, 64'd0);
                end else begin
                    check("inject_data", net_do, out_exp.pop_front());
                    check("inject_vc", {63'd0, net_do[0]}, {63'd0, ~net_polarity});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [63:0] d);
        nicEn = 1'b1; nicEnWR = 1'b1; addr = a; d_in = d;
        tick();
        nicEn = 1'b0; nicEnWR = 1'b0;
    endtask

    task automatic cpu_read(input logic [1:0] a, input logic [63:0] exp, input string tag);
        nicEn = 1'b1; nicEnWR = 1'b0; addr = a;
        tick();
        nicEn = 1'b0;
        check(tag, d_out, exp);
    endtask

    task automatic wait_drain(input string tag, input int max_cycles);
        for (int k = 0; k < max_cycles && out_exp.size() != 0; k++) tick();
        check(tag, 64'(out_exp.size()), 64'd0);
    endtask

    logic [63:0] pk [5];
    logic [63:0] v;

    initial begin
        reset = 1'b0; nicEn = 1'b0; nicEnWR = 1'b0; addr = 2'b00; d_in = '0;
        net_si = 1'b0; net_di = '0; net_ro = 1'b1;
        repeat (3) tick();
        check("rst_d_out", d_out, 64'd0);
        check("rst_net_so", {63'd0, net_so}, 64'd0);
        check("rst_net_do", net_do, 64'd0);
        reset = 1'b1;
        tick();
        check("rst_net_ri", {63'd0, net_ri}, 64'd1);
        cpu_read(A_IN_STAT, 64'd0, "rst_in_stat");
        cpu_read(A_OUT_STAT, 64'd0, "rst_out_stat");

        // Single VC0 packet injects on a polarity-0 edge.
        cpu_write(A_OUT_DATA, 64'h0000_0000_0000_0001);
        out_exp.push_back(64'h0000_0000_0000_0001);
        wait_drain("single_drain", 8);
        cpu_read(A_OUT_STAT, 64'd0, "single_out_stat");

        // Alternating VCs queue up, then leave on consecutive cycles.
        net_ro = 1'b0;
        pk[0] = 64'h0123_4567_89AB_CDE0; pk[1] = 64'h8000_0000_0000_0011;
        pk[2] = 64'h0000_0000_0000_0022; pk[3] = 64'hF000_0000_0000_0033;
        for (int i = 0; i < 4; i++) begin
            cpu_write(A_OUT_DATA, pk[i]);
            out_exp.push_back(pk[i]);
        end
        cpu_read(A_OUT_STAT, 64'h9, "burst_out_stat");
        net_ro = 1'b1;
        for (int k = 0; k < 8 && !net_so; k++) tick();
        check("burst_start", {63'd0, net_so}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("burst_so", {63'd0, net_so}, 64'd1);
        end
        wait_drain("burst_drain", 8);

        // Write into a full FIFO is dropped.
        net_ro = 1'b0;
        pk[0] = 64'h8000_0000_0000_0100; pk[1] = 64'h8000_0000_0000_0101;
        pk[2] = 64'h0000_0000_0000_0102; pk[3] = 64'h0000_0000_0000_0103;
        for (int i = 0; i < 4; i++) begin
            cpu_write(A_OUT_DATA, pk[i]);
            out_exp.push_back(pk[i]);
        end
        cpu_write(A_OUT_DATA, 64'hDEAD_BEEF_DEAD_BEEF);
        cpu_read(A_OUT_STAT, 64'h9 | (ERR ? 64'h200 : 64'h0), "ovf_out_stat");
        cpu_read(A_OUT_STAT, 64'h9, "ovf_out_stat2");
        net_ro = 1'b1;
        wait_drain("ovf_drain", 16);
        repeat (4) tick();

        // Five deliveries into a 4-deep receive FIFO.
        for (int i = 0; i < 5; i++) pk[i] = 64'hA5A5_0000_0000_0000 | 64'(i + 1);
        for (int i = 0; i < 5; i++) begin
            net_si = 1'b1; net_di = pk[i];
            check("rx_net_ri", {63'd0, net_ri}, (i < 4) ? 64'd1 : 64'd0);
            if (i < 4) in_exp.push_back(pk[i]);
            tick();
        end
        net_si = 1'b0;
        cpu_read(A_IN_STAT, 64'h9 | (ERR ? 64'h200 : 64'h0), "rx_in_stat_full");
        while (in_exp.size() != 0) begin
            v = in_exp.pop_front();
            cpu_read(A_IN_DATA, v, "rx_in_data");
        end
        cpu_read(A_IN_STAT, 64'd0, "rx_in_stat_empty");
        cpu_read(A_IN_DATA, 64'd0, "udf_in_data");
        cpu_read(A_IN_STAT, ERR ? 64'h400 : 64'h0, "udf_in_stat");
        cpu_read(A_IN_STAT, 64'd0, "udf_in_stat2");

        // Asynchronous reset with both FIFOs partly full.
        net_ro = 1'b0;
        for (int i = 0; i < 3; i++) cpu_write(A_OUT_DATA, 64'h0000_0000_0000_0200 | 64'(i));
        for (int i = 0; i < 2; i++) begin
            net_si = 1'b1; net_di = 64'h0000_0000_0000_0300 | 64'(i);
            tick();
        end
        net_si = 1'b0;
        cpu_read(A_OUT_STAT, 64'h6, "pre_rst_out_stat");
        cpu_read(A_IN_STAT, 64'h5, "pre_rst_in_stat");
        #2 reset = 1'b0;
        #1;
        check("arst_d_out", d_out, 64'd0);
        check("arst_net_so", {63'd0, net_so}, 64'd0);
        check("arst_net_do", net_do, 64'd0);
        tick();
        reset = 1'b1;
        net_ro = 1'b1;
        repeat (6) tick();
        cpu_read(A_IN_STAT, 64'd0, "post_rst_in_stat");
        cpu_read(A_OUT_STAT, 64'd0, "post_rst_out_stat");
        check("post_rst_net_ri", {63'd0, net_ri}, 64'd1);
        check("final_out_queue", 64'(out_exp.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
